// File: rtl/sum_pkg.sv
// Shared definitions for the digit-serial sum datapath: mode encoding,
// FSM state type and elaboration-time sizing helpers.
package sum_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int beats(input int n, input int w);
    return n / w;
  endfunction

  // Counter width that never collapses to zero bits for single-beat operands.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sum_digit_fa.sv
// W-bit ripple of full-adder cells; also exposes the carry into the MSB so the
// caller can derive signed overflow.
module sum_digit_fa #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] cy;

  // NOTE: blocking assignments in combinational logic, so each cell reads the carry just computed.
  always_comb begin
    cy[0] = ci;
    s     = '0;
    for (int i = 0; i < W; i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = cy[W];
  assign c_msb_in = cy[W-1];

endmodule

// File: rtl/sum_digit_serial.sv
// Digit-serial adder/subtractor: N-bit operands stream in LSB digit first,
// carry/borrow persists across beats, one registered result stage.
module sum_digit_serial
  import sum_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         out_last,
  output logic         cout,
  output logic         ovf
);

  localparam int BEATS = beats(N, W);
  localparam int CW    = clog2_min1(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if ((W < 1) || (N < W) || (N % W != 0)) begin : g_param_check
    $error("sum_digit_serial: N must be a positive multiple of W");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            mode_q, mode_d;
  logic            first, last, accept, mode_eff, carry_in;
  logic [W-1:0]    bx, s;
  logic            co, c_msb_in;

  // clr keeps the input side open; the beat it coincides with is simply dropped.
  assign in_ready = !out_valid | out_ready | clr;
  assign accept   = in_valid & in_ready & !clr;

  assign first    = (state_q == ST_IDLE);
  assign last     = (cnt_q == LAST_BEAT);
  assign mode_eff = first ? sub : mode_q;
  assign carry_in = first ? sub : carry_q;
  assign bx       = b ^ {W{mode_eff == MODE_SUB}};

  sum_digit_fa #(.W(W)) u_fa (
    .a       (a),
    .b       (bx),
    .ci      (carry_in),
    .s       (s),
    .co      (co),
    .c_msb_in(c_msb_in)
  );

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else if (accept) begin
      carry_d = co;
      if (first) mode_d = sub;
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: asynchronous active-low reset, and non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  // Output stage: load on accept, drain on out_ready, otherwise hold stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      c         <= '0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      c         <= s;
      out_last  <= last;
      cout      <= last & co;
      ovf       <= last & (c_msb_in ^ co);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
